// File: rtl/e203_exu_longp_oitf_wbck.sv
// Long-pipe write-back collector with an embedded outstanding-instruction
// tracking FIFO (OITF). Dispatch allocates one tag per long-pipe instruction.
// LSU and divider results are accepted only when their tag matches the FIFO
// head, so retirement is strictly in program order. An errored result goes to
// the commit/exception port instead of the regfile write-back port.
module e203_exu_longp_oitf_wbck #(
  parameter int DEPTH = 2,
  parameter int AW    = 1,
  parameter int XLEN  = 32,
  parameter int RFIDX = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  // dispatch / allocation
  input  logic             disp_ena,
  input  logic             disp_rdwen,
  input  logic [RFIDX-1:0] disp_rdidx,
  output logic [AW-1:0]    disp_itag,
  output logic             oitf_full,
  output logic             oitf_empty,
  // LSU result
  input  logic             lsu_wbck_i_valid,
  output logic             lsu_wbck_i_ready,
  input  logic [XLEN-1:0]  lsu_wbck_i_wdat,
  input  logic [AW-1:0]    lsu_wbck_i_itag,
  input  logic             lsu_wbck_i_err,
  // divider result
  input  logic             div_wbck_i_valid,
  output logic             div_wbck_i_ready,
  input  logic [XLEN-1:0]  div_wbck_i_wdat,
  input  logic [AW-1:0]    div_wbck_i_itag,
  // regfile write-back arbiter
  output logic             longp_wbck_o_valid,
  input  logic             longp_wbck_o_ready,
  output logic [XLEN-1:0]  longp_wbck_o_wdat,
  output logic [RFIDX-1:0] longp_wbck_o_rdidx,
  output logic [4:0]       longp_wbck_o_flags,
  output logic             longp_wbck_o_rdfpu,
  // commit / exception
  output logic             longp_excp_o_valid,
  input  logic             longp_excp_o_ready,
  // retire pulse
  output logic             oitf_ret_ena
);

  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             rdwen_q [DEPTH];
  logic [RFIDX-1:0] rdidx_q [DEPTH];

  logic             push;
  logic             lsu_hit;
  logic             div_hit;
  logic             any_hit;
  logic             head_rdwen;
  logic [RFIDX-1:0] head_rdidx;
  logic             sel_err;
  logic [XLEN-1:0]  sel_wdat;
  logic             wbck_req;
  logic             excp_req;
  logic             accept;

  assign oitf_empty = (wptr == rptr);
  assign oitf_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign disp_itag  = wptr[AW-1:0];
  assign push       = disp_ena & ~oitf_full;

  assign head_rdwen = rdwen_q[rptr[AW-1:0]];
  assign head_rdidx = rdidx_q[rptr[AW-1:0]];

  // A source may only retire the entry at the head of the FIFO.
  assign lsu_hit = lsu_wbck_i_valid & ~oitf_empty & (lsu_wbck_i_itag == rptr[AW-1:0]);
  assign div_hit = div_wbck_i_valid & ~oitf_empty & (div_wbck_i_itag == rptr[AW-1:0]);

  // Select the retiring source (LSU first) and route it to regfile or exception.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    any_hit  = lsu_hit | div_hit;
    sel_err  = 1'b0;
    sel_wdat = div_wbck_i_wdat;
    if (lsu_hit) begin
      sel_err  = lsu_wbck_i_err;
      sel_wdat = lsu_wbck_i_wdat;
    end
    wbck_req = any_hit & ~sel_err & head_rdwen;
    excp_req = any_hit & sel_err;
    if (!any_hit) begin
      accept = 1'b0;
    end else if (sel_err) begin
      accept = longp_excp_o_ready;
    end else if (head_rdwen) begin
      accept = longp_wbck_o_ready;
    end else begin
      accept = 1'b1;
    end
  end

  assign lsu_wbck_i_ready   = lsu_hit & accept;
  assign div_wbck_i_ready   = div_hit & ~lsu_hit & accept;
  assign oitf_ret_ena       = accept;
  assign longp_wbck_o_valid = wbck_req;
  assign longp_wbck_o_wdat  = sel_wdat;
  assign longp_wbck_o_rdidx = head_rdidx;
  assign longp_wbck_o_flags = 5'd0;
  assign longp_wbck_o_rdfpu = 1'b0;
  assign longp_excp_o_valid = excp_req;

  // Advance write pointer on allocation and read pointer on retirement.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)   wptr <= wptr + PTR_ONE;
      if (accept) rptr <= rptr + PTR_ONE;
    end
  end

  // Capture destination info of each allocated instruction.
  // NOTE: the entry array is small, so it is reset to keep every flop at a known value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rdwen_q[i] <= 1'b0;
        rdidx_q[i] <= '0;
      end
    end else if (push) begin
      rdwen_q[wptr[AW-1:0]] <= disp_rdwen;
      rdidx_q[wptr[AW-1:0]] <= disp_rdidx;
    end
  end

  // Both sources matching the head at once means a tag was issued twice.
  a_single_hit : assert property (@(posedge clk) disable iff (!rst_n) !(lsu_hit && div_hit));

endmodule

// File: tb/tb_e203_exu_longp_oitf_wbck.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based OITF model.
module tb_e203_exu_longp_oitf_wbck;

  localparam int DEPTH = 2;
  localparam int AW    = 1;
  localparam int XLEN  = 32;
  localparam int RFIDX = 5;

  logic             clk;
  logic             rst_n;
  logic             disp_ena;
  logic             disp_rdwen;
  logic [RFIDX-1:0] disp_rdidx;
  logic [AW-1:0]    disp_itag;
  logic             oitf_full;
  logic             oitf_empty;
  logic             lsu_valid;
  logic             lsu_ready;
  logic [XLEN-1:0]  lsu_wdat;
  logic [AW-1:0]    lsu_itag;
  logic             lsu_err;
  logic             div_valid;
  logic             div_ready;
  logic [XLEN-1:0]  div_wdat;
  logic [AW-1:0]    div_itag;
  logic             wbck_valid;
  logic             wbck_ready;
  logic [XLEN-1:0]  wbck_wdat;
  logic [RFIDX-1:0] wbck_rdidx;
  logic [4:0]       wbck_flags;
  logic             wbck_rdfpu;
  logic             excp_valid;
  logic             excp_ready;
  logic             ret_ena;

  e203_exu_longp_oitf_wbck #(.DEPTH(DEPTH), .AW(AW), .XLEN(XLEN), .RFIDX(RFIDX)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .disp_ena           (disp_ena),
    .disp_rdwen         (disp_rdwen),
    .disp_rdidx         (disp_rdidx),
    .disp_itag          (disp_itag),
    .oitf_full          (oitf_full),
    .oitf_empty         (oitf_empty),
    .lsu_wbck_i_valid   (lsu_valid),
    .lsu_wbck_i_ready   (lsu_ready),
    .lsu_wbck_i_wdat    (lsu_wdat),
    .lsu_wbck_i_itag    (lsu_itag),
    .lsu_wbck_i_err     (lsu_err),
    .div_wbck_i_valid   (div_valid),
    .div_wbck_i_ready   (div_ready),
    .div_wbck_i_wdat    (div_wdat),
    .div_wbck_i_itag    (div_itag),
    .longp_wbck_o_valid (wbck_valid),
    .longp_wbck_o_ready (wbck_ready),
    .longp_wbck_o_wdat  (wbck_wdat),
    .longp_wbck_o_rdidx (wbck_rdidx),
    .longp_wbck_o_flags (wbck_flags),
    .longp_wbck_o_rdfpu (wbck_rdfpu),
    .longp_excp_o_valid (excp_valid),
    .longp_excp_o_ready (excp_ready),
    .oitf_ret_ena       (ret_ena)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: program-order list of outstanding entries
  typedef struct {
    int       tag;
    bit       rdwen;
    bit [4:0] rdidx;
  } ent_t;

  ent_t q[$];
  int   alloc_cnt;

  bit              exp_acc, exp_lh, exp_dh, exp_wbv, exp_exv;
  logic [XLEN-1:0] exp_wdat;
  bit              last_acc, last_lh, last_dh;

  // Random-driver bookkeeping: which source produces each tag's result.
  bit              ent_src  [DEPTH];
  logic [XLEN-1:0] ent_wdat [DEPTH];
  bit              ent_err  [DEPTH];
  bit              next_src;
  logic [XLEN-1:0] next_wdat;
  bit              next_err;

  task automatic model_eval();
    bit err;
    exp_lh  = lsu_valid && q.size() > 0 && int'(lsu_itag) == q[0].tag;
    exp_dh  = !exp_lh && div_valid && q.size() > 0 && int'(div_itag) == q[0].tag;
    err     = exp_lh ? lsu_err : 1'b0;
    exp_wdat = exp_lh ? lsu_wdat : div_wdat;
    exp_wbv = 0;
    exp_exv = 0;
    exp_acc = 0;
    if (exp_lh || exp_dh) begin
      if (err) begin
        exp_exv = 1;
        exp_acc = excp_ready;
      end else if (q[0].rdwen) begin
        exp_wbv = 1;
        exp_acc = wbck_ready;
      end else begin
        exp_acc = 1;
      end
    end
  endtask

  // Compare every DUT output against the model, away from the active edge.
  task automatic sample();
    @(negedge clk);
    model_eval();
    check("full",       32'(oitf_full),  32'(q.size() == DEPTH));
    check("empty",      32'(oitf_empty), 32'(q.size() == 0));
    check("itag",       32'(disp_itag),  32'(alloc_cnt % DEPTH));
    check("lsu_ready",  32'(lsu_ready),  32'(exp_lh && exp_acc));
    check("div_ready",  32'(div_ready),  32'(exp_dh && exp_acc));
    check("ret_ena",    32'(ret_ena),    32'(exp_acc));
    check("wbck_valid", 32'(wbck_valid), 32'(exp_wbv));
    check("excp_valid", 32'(excp_valid), 32'(exp_exv));
    check("flags",      32'(wbck_flags), 32'd0);
    check("rdfpu",      32'(wbck_rdfpu), 32'd0);
    if (exp_wbv) begin
      check("wdat",  wbck_wdat,         exp_wdat);
      check("rdidx", 32'(wbck_rdidx),   32'(q[0].rdidx));
    end
  endtask

  // Advance the model across the clock edge.
  task automatic commit();
    int n;
    @(posedge clk);
    n = q.size();
    if (exp_acc) void'(q.pop_front());
    if (disp_ena && n < DEPTH) begin
      ent_t e;
      int   t;
      t = alloc_cnt % DEPTH;
      e.tag = t;
      e.rdwen = disp_rdwen;
      e.rdidx = disp_rdidx;
      q.push_back(e);
      ent_src[t]  = next_src;
      ent_wdat[t] = next_wdat;
      ent_err[t]  = next_src ? 1'b0 : next_err;
      alloc_cnt++;
    end
    last_acc = exp_acc;
    last_lh  = exp_lh;
    last_dh  = exp_dh;
    #1;
  endtask

  task automatic idle();
    disp_ena   = 0;
    disp_rdwen = 0;
    disp_rdidx = '0;
    lsu_valid  = 0;
    lsu_wdat   = '0;
    lsu_itag   = '0;
    lsu_err    = 0;
    div_valid  = 0;
    div_wdat   = '0;
    div_itag   = '0;
    wbck_ready = 1;
    excp_ready = 1;
    next_src   = 0;
    next_wdat  = '0;
    next_err   = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    @(posedge clk);
    q.delete();
    alloc_cnt = 0;
    exp_acc = 0;
    last_acc = 0;
    last_lh = 0;
    last_dh = 0;
    #1;
    rst_n = 1;
  endtask

  task automatic dispatch(input bit rdwen, input logic [RFIDX-1:0] rdidx);
    disp_ena   = 1;
    disp_rdwen = rdwen;
    disp_rdidx = rdidx;
    sample();
    commit();
    disp_ena = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    q.delete();
    alloc_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;

    // Reset state
    sample();
    check("rst_empty", 32'(oitf_empty), 32'd1);
    check("rst_full",  32'(oitf_full),  32'd0);
    check("rst_itag",  32'(disp_itag),  32'd0);
    commit();

    // Basic dispatch and same-cycle retire
    disp_ena = 1; disp_rdwen = 1; disp_rdidx = 5'd5;
    sample();
    check("t1_itag", 32'(disp_itag), 32'd0);
    commit();
    disp_ena = 0;
    lsu_valid = 1; lsu_wdat = 32'hDEADBEEF; lsu_itag = 0; lsu_err = 0;
    sample();
    check("t1_wbv",   32'(wbck_valid), 32'd1);
    check("t1_rdidx", 32'(wbck_rdidx), 32'd5);
    check("t1_wdat",  wbck_wdat,       32'hDEADBEEF);
    check("t1_lrdy",  32'(lsu_ready),  32'd1);
    check("t1_ret",   32'(ret_ena),    32'd1);
    commit();
    lsu_valid = 0;
    sample();
    check("t1_empty", 32'(oitf_empty), 32'd1);
    commit();

    // Full: third dispatch ignored, retire frees a slot
    do_reset();
    dispatch(1, 5'd1);
    dispatch(1, 5'd2);
    disp_ena = 1; disp_rdidx = 5'd3;
    sample();
    check("t2_full", 32'(oitf_full), 32'd1);
    check("t2_itag", 32'(disp_itag), 32'd0);
    commit();
    disp_ena = 0;
    lsu_valid = 1; lsu_itag = 0; lsu_wdat = 32'h1111;
    sample();
    check("t2_ret",   32'(ret_ena),   32'd1);
    check("t2_full2", 32'(oitf_full), 32'd1);
    commit();
    lsu_valid = 0;
    sample();
    check("t2_notfull", 32'(oitf_full), 32'd0);
    check("t2_itag2",   32'(disp_itag), 32'd0);
    commit();

    // Out-of-order arrival: divider waits for the head
    do_reset();
    dispatch(1, 5'd10);
    dispatch(1, 5'd11);
    div_valid = 1; div_itag = 1; div_wdat = 32'h2222;
    sample();
    check("t3_drdy0", 32'(div_ready), 32'd0);
    check("t3_ret0",  32'(ret_ena),   32'd0);
    commit();
    lsu_valid = 1; lsu_itag = 0; lsu_wdat = 32'h1111;
    sample();
    check("t3_lrdy",   32'(lsu_ready),  32'd1);
    check("t3_drdy1",  32'(div_ready),  32'd0);
    check("t3_rdidx0", 32'(wbck_rdidx), 32'd10);
    commit();
    lsu_valid = 0;
    sample();
    check("t3_drdy2",  32'(div_ready),  32'd1);
    check("t3_rdidx1", 32'(wbck_rdidx), 32'd11);
    check("t3_wdat1",  wbck_wdat,       32'h2222);
    commit();
    div_valid = 0;
    sample();
    check("t3_empty", 32'(oitf_empty), 32'd1);
    commit();

    // Back-pressure from the write-back arbiter
    do_reset();
    dispatch(1, 5'd9);
    lsu_valid = 1; lsu_itag = 0; lsu_wdat = 32'hCAFEF00D;
    wbck_ready = 0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("t4_hold_v",     32'(wbck_valid), 32'd1);
      check("t4_hold_wdat",  wbck_wdat,       32'hCAFEF00D);
      check("t4_hold_rdidx", 32'(wbck_rdidx), 32'd9);
      check("t4_hold_ret",   32'(ret_ena),    32'd0);
      commit();
    end
    wbck_ready = 1;
    sample();
    check("t4_ret", 32'(ret_ena), 32'd1);
    commit();
    lsu_valid = 0;
    sample();
    check("t4_empty", 32'(oitf_empty), 32'd1);
    commit();

    // Errored load routed to the exception port
    do_reset();
    dispatch(1, 5'd4);
    lsu_valid = 1; lsu_itag = 0; lsu_err = 1; lsu_wdat = 32'h5555;
    excp_ready = 0;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("t5_exv",  32'(excp_valid), 32'd1);
      check("t5_wbv",  32'(wbck_valid), 32'd0);
      check("t5_ret0", 32'(ret_ena),    32'd0);
      commit();
    end
    excp_ready = 1;
    sample();
    check("t5_ret",  32'(ret_ena),   32'd1);
    check("t5_lrdy", 32'(lsu_ready), 32'd1);
    commit();
    lsu_valid = 0; lsu_err = 0;

    // Pointer wrap: itag sequence 0,1,0,1,0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      disp_ena = 1; disp_rdwen = 1; disp_rdidx = 5'(i + 1);
      sample();
      check("t6_itag", 32'(disp_itag), 32'(i % 2));
      commit();
      disp_ena = 0;
      lsu_valid = 1; lsu_itag = AW'(i % 2); lsu_wdat = 32'(i);
      sample();
      check("t6_ret",   32'(ret_ena),    32'd1);
      check("t6_rdidx", 32'(wbck_rdidx), 32'(i + 1));
      commit();
      lsu_valid = 0;
    end

    // Randomized traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (last_acc && last_lh) lsu_valid = 0;
      if (last_acc && last_dh) div_valid = 0;
      if (!lsu_valid && ($urandom % 2 == 0)) begin
        foreach (q[i]) begin
          if (!lsu_valid && ent_src[q[i].tag] == 0) begin
            lsu_valid = 1;
            lsu_itag  = AW'(q[i].tag);
            lsu_wdat  = ent_wdat[q[i].tag];
            lsu_err   = ent_err[q[i].tag];
          end
        end
      end
      if (!div_valid && ($urandom % 2 == 0)) begin
        foreach (q[i]) begin
          if (!div_valid && ent_src[q[i].tag] == 1) begin
            div_valid = 1;
            div_itag  = AW'(q[i].tag);
            div_wdat  = ent_wdat[q[i].tag];
          end
        end
      end
      disp_ena   = ($urandom % 2 == 0);
      disp_rdwen = ($urandom % 4 != 0);
      disp_rdidx = RFIDX'($urandom);
      next_src   = $urandom % 2 == 0;
      next_wdat  = $urandom;
      next_err   = ($urandom % 6 == 0);
      wbck_ready = ($urandom % 4 != 0);
      excp_ready = ($urandom % 2 == 0);
      sample();
      commit();
    end

    // Reset with two entries outstanding and both sources presenting
    do_reset();
    dispatch(1, 5'd20);
    dispatch(1, 5'd21);
    lsu_valid = 1; lsu_itag = 0; lsu_wdat = 32'h77;
    div_valid = 1; div_itag = 1; div_wdat = 32'h88;
    rst_n = 0;
    #1;
    check("t7_empty", 32'(oitf_empty), 32'd1);
    check("t7_full",  32'(oitf_full),  32'd0);
    check("t7_lrdy",  32'(lsu_ready),  32'd0);
    check("t7_drdy",  32'(div_ready),  32'd0);
    check("t7_ret",   32'(ret_ena),    32'd0);
    check("t7_wbv",   32'(wbck_valid), 32'd0);
    q.delete();
    alloc_cnt = 0;
    sample();
    @(posedge clk);
    #1;
    idle();
    rst_n = 1;
    sample();
    commit();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
